// File: rtl/ccip_host_mem_responder_if.sv
// CCI-P channel types and the AFU <-> host bus bundle used by the
// host-memory responder.
package ccip_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        logic [1:0]   vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

endpackage

interface ccip_host_mem_responder_if;
    import ccip_pkg::*;

    t_if_ccip_Tx af2cp_tx;
    t_if_ccip_Rx cp2af_rx;

    modport master (output af2cp_tx, input cp2af_rx);
    modport slave  (input af2cp_tx, output cp2af_rx);
endinterface

// File: rtl/ccip_host_mem_responder.sv
// Host-memory stand-in for a CCI-P AFU: line-addressed backing store
// with per-channel, latency-ordered response FIFOs.

module ccip_hmr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = {1'b1, {PW{1'b0}}};

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            store[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ccip_host_mem_responder
    import ccip_pkg::*;
#(
    parameter int MEM_LINES      = 1024,
    parameter int FIFO_DEPTH     = 32,
    parameter int LATENCY        = 16,
    parameter int ALMFULL_MARGIN = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    ccip_host_mem_responder_if.slave bus,
    output logic                    err_overflow,
    output logic                    err_badlen
);
    localparam int AW = $clog2(MEM_LINES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] ALM_THR = CW'(FIFO_DEPTH - ALMFULL_MARGIN);
    localparam logic [7:0] LAT = 8'(LATENCY);

    typedef struct packed {
        t_ccip_mdata   mdata;
        logic [AW-1:0] idx;
        logic [3:0]    typ;
        logic [7:0]    ts;
    } ent_t;

    t_if_ccip_Tx   tx;
    t_if_ccip_Rx   rx_d;
    t_if_ccip_Rx   rx_q;
    ent_t          rd_in;
    ent_t          wr_in;
    ent_t          rd_head;
    ent_t          wr_head;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic [7:0]    tick;
    logic [511:0]  mem [MEM_LINES];
    logic          rd_req;
    logic          wr_req;
    logic          wr_line;
    logic          wr_fence;
    logic          bad_len;
    logic          ovf;
    logic          rd_pop;
    logic          wr_pop;
    logic          unused_bits;

    assign tx           = bus.af2cp_tx;
    assign bus.cp2af_rx = rx_q;

    assign rd_req = tx.c0.valid &&
                    (tx.c0.hdr.req_type == eREQ_RDLINE_I ||
                     tx.c0.hdr.req_type == eREQ_RDLINE_S);
    assign wr_line = tx.c1.valid &&
                     (tx.c1.hdr.req_type == eREQ_WRLINE_I ||
                      tx.c1.hdr.req_type == eREQ_WRLINE_M);
    assign wr_fence = tx.c1.valid &&
                      (tx.c1.hdr.req_type == eREQ_WRFENCE);
    assign wr_req = wr_line || wr_fence;

    assign bad_len = (rd_req && tx.c0.hdr.cl_len != eCL_LEN_1) ||
                     (wr_req && tx.c1.hdr.cl_len != eCL_LEN_1);
    assign ovf = (rd_req && rd_cnt == FULL) ||
                 (wr_req && wr_cnt == FULL);

    always_comb begin
        rd_in       = '0;
        rd_in.mdata = tx.c0.hdr.mdata;
        rd_in.idx   = tx.c0.hdr.address[AW-1:0];
        rd_in.typ   = tx.c0.hdr.req_type;
        rd_in.ts    = tick;
        wr_in       = '0;
        wr_in.mdata = tx.c1.hdr.mdata;
        wr_in.idx   = tx.c1.hdr.address[AW-1:0];
        wr_in.typ   = tx.c1.hdr.req_type;
        wr_in.ts    = tick;
    end

    // Age is mod-256, so the head matures exactly LATENCY edges after push.
    assign rd_pop = (rd_cnt != '0) && ((tick - rd_head.ts) >= LAT);
    assign wr_pop = (wr_cnt != '0) && ((tick - wr_head.ts) >= LAT);

    ccip_hmr_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_req),
        .pop   (rd_pop),
        .din   (rd_in),
        .head  (rd_head),
        .count (rd_cnt)
    );

    ccip_hmr_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_req),
        .pop   (wr_pop),
        .din   (wr_in),
        .head  (wr_head),
        .count (wr_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
        end else begin
            tick <= tick + 8'd1;
        end
    end

    // Write lands even when the FIFO push is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_line) begin
            mem[tx.c1.hdr.address[AW-1:0]] <= tx.c1.data;
        end
    end

    always_comb begin
        rx_d                  = '0;
        rx_d.c0TxAlmFull      = (rd_cnt >= ALM_THR);
        rx_d.c1TxAlmFull      = (wr_cnt >= ALM_THR);
        rx_d.c0.hdr.resp_type = eRSP_RDLINE;
        rx_d.c1.hdr.resp_type = eRSP_WRLINE;
        if (rd_pop) begin
            rx_d.c0.rspValid  = 1'b1;
            rx_d.c0.hdr.mdata = rd_head.mdata;
            rx_d.c0.data      = mem[rd_head.idx];
        end
        if (wr_pop) begin
            rx_d.c1.rspValid  = 1'b1;
            rx_d.c1.hdr.mdata = wr_head.mdata;
            if (wr_head.typ == eREQ_WRFENCE) begin
                rx_d.c1.hdr.resp_type = eRSP_WRFENCE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q         <= '0;
            err_overflow <= 1'b0;
            err_badlen   <= 1'b0;
        end else begin
            rx_q         <= rx_d;
            err_overflow <= err_overflow | ovf;
            err_badlen   <= err_badlen | bad_len;
        end
    end

    assign unused_bits = ^{tx, rd_head.typ, wr_head.idx};
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Directed bench for ccip_host_mem_responder: ordering, latency,
// hazards, overflow, bad length and reset flush.
module tb_ccip_host_mem_responder;
    import ccip_pkg::*;

    typedef struct {
        logic [15:0]  mdata;
        logic [511:0] data;
        logic [3:0]   typ;
        int           cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_ovf_a;
    logic err_bad_a;
    logic err_ovf_b;
    logic err_bad_b;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    rsp_t q0[$];
    rsp_t q1[$];
    rsp_t qs[$];

    ccip_host_mem_responder_if bus_a ();
    ccip_host_mem_responder_if bus_b ();

    ccip_host_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_a),
        .err_overflow (err_ovf_a),
        .err_badlen   (err_bad_a)
    );

    ccip_host_mem_responder #(.LATENCY(48)) dut_slow (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_b),
        .err_overflow (err_ovf_b),
        .err_badlen   (err_bad_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.cp2af_rx.c0.rspValid)
            q0.push_back('{bus_a.cp2af_rx.c0.hdr.mdata,
                           bus_a.cp2af_rx.c0.data,
                           4'(bus_a.cp2af_rx.c0.hdr.resp_type), cyc});
        if (bus_a.cp2af_rx.c1.rspValid)
            q1.push_back('{bus_a.cp2af_rx.c1.hdr.mdata, 512'd0,
                           4'(bus_a.cp2af_rx.c1.hdr.resp_type), cyc});
        if (bus_b.cp2af_rx.c0.rspValid)
            qs.push_back('{bus_b.cp2af_rx.c0.hdr.mdata,
                           bus_b.cp2af_rx.c0.data,
                           4'(bus_b.cp2af_rx.c0.hdr.resp_type), cyc});
    end

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [41:0] a, input logic [15:0] md,
                      input logic [3:0] rt, input t_ccip_clLen len,
                      output int t);
        bus_a.af2cp_tx.c0.hdr          = '0;
        bus_a.af2cp_tx.c0.hdr.address  = a;
        bus_a.af2cp_tx.c0.hdr.mdata    = md;
        bus_a.af2cp_tx.c0.hdr.req_type = t_ccip_c0_req'(rt);
        bus_a.af2cp_tx.c0.hdr.cl_len   = len;
        bus_a.af2cp_tx.c0.valid        = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus_a.af2cp_tx.c0.valid = 1'b0;
    endtask

    task automatic wr(input logic [41:0] a, input logic [15:0] md,
                      input t_ccip_c1_req rt, input logic [511:0] d,
                      output int t);
        bus_a.af2cp_tx.c1.hdr          = '0;
        bus_a.af2cp_tx.c1.hdr.address  = a;
        bus_a.af2cp_tx.c1.hdr.mdata    = md;
        bus_a.af2cp_tx.c1.hdr.req_type = rt;
        bus_a.af2cp_tx.c1.hdr.cl_len   = eCL_LEN_1;
        bus_a.af2cp_tx.c1.hdr.sop      = 1'b1;
        bus_a.af2cp_tx.c1.data         = d;
        bus_a.af2cp_tx.c1.valid        = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus_a.af2cp_tx.c1.valid = 1'b0;
    endtask

    task automatic rd_b(input logic [41:0] a, input logic [15:0] md);
        bus_b.af2cp_tx.c0.hdr          = '0;
        bus_b.af2cp_tx.c0.hdr.address  = a;
        bus_b.af2cp_tx.c0.hdr.mdata    = md;
        bus_b.af2cp_tx.c0.hdr.req_type = eREQ_RDLINE_S;
        bus_b.af2cp_tx.c0.valid        = 1'b1;
        @(negedge clk);
        bus_b.af2cp_tx.c0.valid = 1'b0;
    endtask

    initial begin
        int t;
        int t0;
        int tw;
        int tr;
        logic [511:0] d_a5;
        logic [511:0] d_x;
        logic [511:0] d_y;
        logic [511:0] d_z;
        d_a5 = {64{8'hA5}};
        d_x  = {16{32'hDEAD_0007}};
        d_y  = {16{32'h0BAD_F00D}};
        d_z  = {8{64'h0123_4567_89AB_CDEF}};
        bus_a.af2cp_tx = '0;
        bus_b.af2cp_tx = '0;

        reset = 1'b1;
        idle(3);
        check("rst_c0_valid", bus_a.cp2af_rx.c0.rspValid, 0);
        check("rst_c1_valid", bus_a.cp2af_rx.c1.rspValid, 0);
        check("rst_c0_alm", bus_a.cp2af_rx.c0TxAlmFull, 0);
        check("rst_c1_alm", bus_a.cp2af_rx.c1TxAlmFull, 0);
        check("rst_ovf", err_ovf_a, 0);
        check("rst_badlen", err_bad_a, 0);
        check("rst_slow_alm", bus_b.cp2af_rx.c0TxAlmFull, 0);
        reset = 1'b0;
        idle(2);

        wr(5, 16'h11, eREQ_WRLINE_I, d_a5, tw);
        rd(5, 16'h22, eREQ_RDLINE_I, eCL_LEN_1, tr);
        idle(20);
        check("wr_rsp_cnt", q1.size(), 1);
        check("wr_rsp_mdata", q1[0].mdata, 16'h11);
        check("wr_rsp_type", q1[0].typ, 4'h0);
        check("wr_rsp_cyc", q1[0].cyc, tw + 16);
        check("rd_rsp_cnt", q0.size(), 1);
        check("rd_rsp_mdata", q0[0].mdata, 16'h22);
        check("rd_rsp_data", q0[0].data, d_a5);
        check("rd_rsp_cyc", q0[0].cyc, tr + 16);
        q0.delete();
        q1.delete();

        rd(6, 16'h33, 4'h3, eCL_LEN_1, t);
        idle(20);
        check("ignored_type", q0.size(), 0);

        wr(7, 16'h70, eREQ_WRLINE_M, d_x, tw);
        idle(20);
        q1.delete();
        rd(7, 16'h71, eREQ_RDLINE_I, eCL_LEN_1, tr);
        idle(15);
        wr(7, 16'h72, eREQ_WRLINE_I, d_y, tw);
        rd(7, 16'h73, eREQ_RDLINE_I, eCL_LEN_1, t);
        idle(20);
        check("hazard_cnt", q0.size(), 2);
        check("hazard_old", q0[0].data, d_x);
        check("hazard_new", q0[1].data, d_y);
        q0.delete();
        q1.delete();

        for (int i = 0; i < 32; i++) begin
            rd(42'(i), 16'(i), eREQ_RDLINE_I, eCL_LEN_1, t);
            if (i == 0) t0 = t;
        end
        idle(30);
        check("b2b_cnt", q0.size(), 32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("b2b_mdata_%0d", i), q0[i].mdata, 16'(i));
            check($sformatf("b2b_cyc_%0d", i), q0[i].cyc, t0 + 16 + i);
        end
        q0.delete();

        wr(1, 16'h31, eREQ_WRLINE_I, d_x, tw);
        wr(2, 16'h32, eREQ_WRLINE_I, d_x, t);
        wr(3, 16'h33, eREQ_WRLINE_M, d_x, t);
        wr(0, 16'h34, eREQ_WRFENCE, 512'd0, t);
        idle(25);
        check("fence_cnt", q1.size(), 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fence_wr_type_%0d", i), q1[i].typ, 4'h0);
            check($sformatf("fence_wr_mdata_%0d", i), q1[i].mdata,
                  16'h31 + 16'(i));
        end
        check("fence_type", q1[3].typ, 4'h4);
        check("fence_mdata", q1[3].mdata, 16'h34);
        check("fence_cyc", q1[3].cyc, tw + 19);
        q1.delete();

        wr(0, 16'h40, eREQ_WRLINE_I, d_z, t);
        idle(2);
        check("badlen_before", err_bad_a, 0);
        rd(42'h400, 16'h55, eREQ_RDLINE_I, eCL_LEN_2, tr);
        idle(20);
        check("badlen_after", err_bad_a, 1);
        check("badlen_cnt", q0.size(), 1);
        check("badlen_mdata", q0[0].mdata, 16'h55);
        check("badlen_data", q0[0].data, d_z);
        check("badlen_cyc", q0[0].cyc, tr + 16);
        check("no_ovf_a", err_ovf_a, 0);
        q0.delete();
        q1.delete();

        for (int i = 1; i <= 33; i++) begin
            rd_b(42'(i - 1), 16'h100 + 16'(i - 1));
            if (i == 24) check("alm_at_24", bus_b.cp2af_rx.c0TxAlmFull, 0);
            if (i == 25) check("alm_at_25", bus_b.cp2af_rx.c0TxAlmFull, 1);
            if (i == 32) check("ovf_at_32", err_ovf_b, 0);
        end
        check("ovf_at_33", err_ovf_b, 1);
        idle(100);
        check("ovf_rsp_cnt", qs.size(), 32);
        for (int i = 0; i < 32; i++)
            check($sformatf("ovf_mdata_%0d", i), qs[i].mdata,
                  16'h100 + 16'(i));
        check("alm_drained", bus_b.cp2af_rx.c0TxAlmFull, 0);

        for (int i = 0; i < 10; i++)
            rd(42'(i + 64), 16'h200 + 16'(i), eREQ_RDLINE_I, eCL_LEN_1, t);
        idle(3);
        reset = 1'b1;
        rd(9, 16'h66, eREQ_RDLINE_I, eCL_LEN_1, t);
        check("mid_rst_c0_valid", bus_a.cp2af_rx.c0.rspValid, 0);
        check("mid_rst_c1_valid", bus_a.cp2af_rx.c1.rspValid, 0);
        check("mid_rst_c0_mdata", bus_a.cp2af_rx.c0.hdr.mdata, 0);
        check("mid_rst_c0_alm", bus_a.cp2af_rx.c0TxAlmFull, 0);
        check("mid_rst_badlen", err_bad_a, 0);
        check("mid_rst_ovf_b", err_ovf_b, 0);
        reset = 1'b0;
        q0.delete();
        idle(40);
        check("flushed", q0.size(), 0);
        rd(3, 16'h77, eREQ_RDLINE_I, eCL_LEN_1, tr);
        idle(20);
        check("post_rst_cnt", q0.size(), 1);
        check("post_rst_mdata", q0[0].mdata, 16'h77);
        check("post_rst_cyc", q0[0].cyc, tr + 16);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
